// File: rtl/div_seq_n.sv
// ---------------------------------------------------------------------------
// div_seq_n : sequential restoring divider with start/busy/done handshake.
//
// One quotient bit is produced per clock. A zero divisor is detected when
// the request is accepted and answered at once with quotient = all ones,
// remainder = dividend and dv0 = 1. Results are held on the outputs until
// the next accepted request; done stays high for DONE_HOLD cycles.
//
// Optional feature (macro SIGNED_DIV_EN): operands are two's complement.
// The magnitudes are divided, and one extra FIX cycle applies the signs
// (truncating division). When the macro is undefined the divider is
// unsigned only and the FIX state does not exist.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//   DONE_HOLD  cycles that done stays high (>= 1)
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   start      request, sampled only while idle
//   dividend   numerator, latched when start is accepted
//   divisor    denominator, latched when start is accepted
//   quotient   registered quotient
//   remainder  registered remainder
//   busy       high while iterations are in progress
//   done       high for DONE_HOLD cycles while results are valid
//   dv0        divisor was zero for the current result
// ---------------------------------------------------------------------------
module div_seq_n #(
   parameter int WIDTH     = 16,
   parameter int DONE_HOLD = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             dv0
);

   localparam int CW = $clog2(WIDTH);
   localparam int HW = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(DONE_HOLD - 1);

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   // Two's complement magnitude; the most negative value maps onto itself,
   // which is its correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      magnitude = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction
`else
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] q, q_nxt;
   logic [WIDTH-1:0] dsr, dsr_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [WIDTH-1:0] quotient_nxt, remainder_nxt;
   logic             busy_nxt, done_nxt, dv0_nxt;
`ifdef SIGNED_DIV_EN
   logic             neg_q, neg_q_nxt;
   logic             neg_r, neg_r_nxt;
`endif

   // One restoring step. acc is always below the divisor, so the shifted
   // value fits in WIDTH+1 bits and the trial sign bit is exact.
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] acc_step;
   logic [WIDTH-1:0] q_step;

   // Datapath for a single iteration: shift, trial subtract, restore or keep.
   always_comb begin
      shifted = {acc, q[WIDTH-1]};
      trial   = shifted - {1'b0, dsr};
      if (trial[WIDTH] == 1'b0) begin
         acc_step = trial[WIDTH-1:0];
         q_step   = {q[WIDTH-2:0], 1'b1};
      end else begin
         acc_step = shifted[WIDTH-1:0];
         q_step   = {q[WIDTH-2:0], 1'b0};
      end
   end

   // Next-state and next-value logic for the sequencer and datapath.
   always_comb begin
      state_nxt     = state;
      acc_nxt       = acc;
      q_nxt         = q;
      dsr_nxt       = dsr;
      cnt_nxt       = cnt;
      hold_nxt      = hold_cnt;
      quotient_nxt  = quotient;
      remainder_nxt = remainder;
      busy_nxt      = busy;
      done_nxt      = done;
      dv0_nxt       = dv0;
`ifdef SIGNED_DIV_EN
      neg_q_nxt     = neg_q;
      neg_r_nxt     = neg_r;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               dv0_nxt = 1'b0;
               if (divisor == '0) begin
                  // Divide by zero is answered immediately, no iterations.
                  state_nxt     = DONE;
                  quotient_nxt  = '1;
                  remainder_nxt = dividend;
                  dv0_nxt       = 1'b1;
                  done_nxt      = 1'b1;
                  hold_nxt      = '0;
               end else begin
                  state_nxt = ITER;
                  busy_nxt  = 1'b1;
                  cnt_nxt   = '0;
                  acc_nxt   = '0;
`ifdef SIGNED_DIV_EN
                  q_nxt     = magnitude(dividend);
                  dsr_nxt   = magnitude(divisor);
                  neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  neg_r_nxt = dividend[WIDTH-1];
`else
                  q_nxt     = dividend;
                  dsr_nxt   = divisor;
`endif
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         ITER: begin
            acc_nxt = acc_step;
            q_nxt   = q_step;
            cnt_nxt = cnt + CW'(1);
            if (cnt == LAST_ITER) begin
               busy_nxt = 1'b0;
`ifdef SIGNED_DIV_EN
               // Outputs are written only after sign correction so that no
               // unsigned intermediate is ever presented.
               state_nxt = FIX;
`else
               state_nxt     = DONE;
               quotient_nxt  = q_step;
               remainder_nxt = acc_step;
               done_nxt      = 1'b1;
               hold_nxt      = '0;
`endif
            end else begin
               state_nxt = ITER;
            end
         end
`ifdef SIGNED_DIV_EN
         FIX: begin
            state_nxt     = DONE;
            quotient_nxt  = neg_q ? (~q + WIDTH'(1)) : q;
            remainder_nxt = neg_r ? (~acc + WIDTH'(1)) : acc;
            done_nxt      = 1'b1;
            hold_nxt      = '0;
         end
`endif
         DONE: begin
            if (hold_cnt == LAST_HOLD) begin
               state_nxt = IDLE;
               done_nxt  = 1'b0;
            end else begin
               state_nxt = DONE;
               hold_nxt  = hold_cnt + HW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         acc       <= '0;
         q         <= '0;
         dsr       <= '0;
         cnt       <= '0;
         hold_cnt  <= '0;
         quotient  <= '0;
         remainder <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         dv0       <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         acc       <= acc_nxt;
         q         <= q_nxt;
         dsr       <= dsr_nxt;
         cnt       <= cnt_nxt;
         hold_cnt  <= hold_nxt;
         quotient  <= quotient_nxt;
         remainder <= remainder_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         dv0       <= dv0_nxt;
`ifdef SIGNED_DIV_EN
         neg_q     <= neg_q_nxt;
         neg_r     <= neg_r_nxt;
`endif
      end
   end

endmodule

// File: doc/div_seq_n.md
Name: div_seq_n

Overview:
Parametrised sequential restoring divider. Control sequencer and datapath are integrated in one block, which replaces the fixed 16-bit split control/datapath divider. It produces one quotient bit per clock and has a start/busy/done handshake, divide-by-zero detection and a programmable done-hold window. It serves measurement paths (distance/timing scaling) that feed display and game logic.

Parameters:
WIDTH, 16, operand and result width in bits (2..32)
DONE_HOLD, 10, number of cycles done stays high with results valid (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  request; sampled only in IDLE
dividend  in  WIDTH  numerator; latched when start is accepted
divisor  in  WIDTH  denominator; latched when start is accepted
quotient  out  WIDTH  result quotient, registered
remainder  out  WIDTH  result remainder, registered
busy  out  1  high while an iteration is in progress
done  out  1  high for DONE_HOLD cycles when results are valid
dv0  out  1  divisor was zero for the current result

Behaviour:
- Reset (rst=0, async): state=IDLE; quotient=0, remainder=0, busy=0, done=0, dv0=0; iteration counter=0.
- States: IDLE, ITER, FIX (only when SIGNED_DIV_EN is defined), DONE.
- IDLE, start=1 sampled at edge E:
  - Latch the operands and clear dv0.
  - If divisor==0: go to DONE at E. Set quotient=all ones, remainder=dividend, dv0=1.
  - Otherwise go to ITER. Set busy=1, counter=0, acc=0, q=dividend.
- ITER, each edge:
  - {acc,q} shifts left by 1.
  - trial = shifted acc - divisor, computed at WIDTH+1 bits.
  - If trial is non-negative: acc=trial and q[0]=1. Otherwise acc is restored and q[0]=0.
  - counter increments. After iteration WIDTH-1 (edge E+WIDTH), go to DONE (or FIX), with quotient=q, remainder=acc, busy=0.
- Latency (unsigned, nonzero divisor): done=1 after edge E+WIDTH.
- Latency (divide by zero): done=1 after edge E.
- DONE: done=1 for exactly DONE_HOLD cycles, counted by a dedicated counter, then return to IDLE with done=0.
- Result holding: quotient, remainder and dv0 hold their values after DONE until the next accepted start.
- start is ignored in ITER, FIX and DONE. There is no queuing.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Simultaneous start and rst=0: reset wins.
- Reset mid-ITER aborts the operation and clears all outputs. No partial result is visible.
- Edge operands:
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - dividend<divisor gives q=0, r=dividend.

Optional Feature:
Macro SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement. Magnitudes are taken at latch time.
  - After ITER, one FIX cycle negates the quotient if the operand signs differ and negates the remainder if the dividend is negative (truncating division).
  - Latency becomes WIDTH+1.
  - Most-negative / -1 wraps to q=most-negative, r=0.
  - Divide by zero gives q=all ones, r=dividend, dv0=1, and skips FIX.
- Undefined: unsigned only, the FIX state does not exist, and latency is WIDTH.

Test Plan:
- WIDTH=16, 1000/7, start at edge E -> busy for 16 cycles; done after E+16; q=142, r=6, dv0=0.
- 1234/0 -> done after E; q=0xFFFF, r=1234, dv0=1; done high exactly 10 cycles, then IDLE.
- start pulsed again during ITER (operands 50/5) -> ignored; first result 1000/7 unchanged; a new start after done falls is accepted.
- rst=0 at ITER cycle 8 -> all outputs 0 immediately; a subsequent 65535/255 -> q=257, r=0.
- DONE_HOLD=1, back-to-back starts held high -> done high for 1 cycle; next accepted start is on the edge after done falls.
- SIGNED_DIV_EN, -100/7 -> q=0xFFF2 (-14), r=0xFFFE (-2), done after E+17; 0x8000/0xFFFF -> q=0x8000, r=0.
